// File: rtl/core_phase_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// core_phase_sequencer_pkg
//   Shared definitions for the RockWave phase sequencer: the 3-bit phase
//   state encoding, default widths, and small decode helpers used by the
//   sequencer top.
// ---------------------------------------------------------------------------
package core_phase_sequencer_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int CNTW_DEFAULT = 64;

    // Width of the registered strobe vector: five phases plus halted.
    localparam int ONEHOT_W = 6;

    // Bit positions inside the registered strobe vector.
    localparam int OH_FETCH   = 0;
    localparam int OH_DECODE  = 1;
    localparam int OH_EXECUTE = 2;
    localparam int OH_MEMACC  = 3;
    localparam int OH_WB      = 4;
    localparam int OH_HALT    = 5;

    typedef enum logic [2:0] {
        PH_RST     = 3'd0,
        PH_FETCH   = 3'd1,
        PH_DECODE  = 3'd2,
        PH_EXECUTE = 3'd3,
        PH_MEMACC  = 3'd4,
        PH_WB      = 3'd5,
        PH_HALT    = 3'd6
    } phase_t;

    // Strobe vector for a given state; all-zero in RST (and for the unused code).
    function automatic logic [ONEHOT_W-1:0] phase_onehot(input phase_t p);
        logic [ONEHOT_W-1:0] v;
        v = '0;
        case (p)
            PH_FETCH:   v[OH_FETCH]   = 1'b1;
            PH_DECODE:  v[OH_DECODE]  = 1'b1;
            PH_EXECUTE: v[OH_EXECUTE] = 1'b1;
            PH_MEMACC:  v[OH_MEMACC]  = 1'b1;
            PH_WB:      v[OH_WB]      = 1'b1;
            PH_HALT:    v[OH_HALT]    = 1'b1;
            default:    v             = '0;
        endcase
        return v;
    endfunction

    // The cycle counter only advances while the core is actually sequencing.
    function automatic logic counts_cycle(input phase_t p);
        return (p != PH_RST) && (p != PH_HALT);
    endfunction

endpackage

// File: rtl/core_phase_sequencer_phase_counter.sv
// ---------------------------------------------------------------------------
// core_phase_sequencer_phase_counter
//   Free-running CNTW-bit event counter with synchronous clear and count
//   enable. Wraps modulo 2^CNTW with no saturation or overflow flag.
// Ports:
//   clk  in   1     rising-edge clock
//   clr  in   1     synchronous clear (active high, wins over en)
//   en   in   1     increment on this edge
//   cnt  out  CNTW  current count
// ---------------------------------------------------------------------------
module core_phase_sequencer_phase_counter
    import core_phase_sequencer_pkg::*;
#(
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    output logic [CNTW-1:0] cnt
);

    logic [CNTW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + CNTW'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/core_phase_sequencer.sv
// ---------------------------------------------------------------------------
// core_phase_sequencer
//   Multi-cycle phase controller for the RockWave core. Walks
//   FETCH -> DECODE -> EXECUTE -> MEMACC -> WB, holding a phase while that
//   stage stalls, with halt / single-step for debug, plus cycle and
//   retired-instruction counters. All outputs are registered.
// Ports:
//   clk                 in   1     rising-edge clock
//   rst_n               in   1     synchronous active-low reset
//   stall_fetch..wb     in   1     per-stage stall; only the active phase's stall matters
//   halt_req            in   1     level; park in HALT at the next WB exit
//   step_req            in   1     level; from HALT, run exactly one instruction
//   phase_*             out  1     one-hot phase strobes
//   halted              out  1     HALT active
//   retire              out  1     one-cycle pulse after each WB exit
//   cycle_cnt           out  CNTW  cycles spent outside RST/HALT since reset
//   instret_cnt         out  CNTW  instructions retired since reset
// ---------------------------------------------------------------------------
module core_phase_sequencer
    import core_phase_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_fetch,
    input  logic            stall_decode,
    input  logic            stall_execute,
    input  logic            stall_memoryaccess,
    input  logic            stall_writeback,
    input  logic            halt_req,
    input  logic            step_req,
    output logic            phase_fetch,
    output logic            phase_decode,
    output logic            phase_execute,
    output logic            phase_memoryaccess,
    output logic            phase_writeback,
    output logic            halted,
    output logic            retire,
    output logic [CNTW-1:0] cycle_cnt,
    output logic [CNTW-1:0] instret_cnt
);

    // XLEN only documents the core width this sequencer is paired with.
    if (XLEN < 1) begin : g_xlen_unused
    end

    phase_t                state_reg, state_next;
    logic                  step_pending_reg, step_pending_next;
    logic [ONEHOT_W-1:0]   onehot_reg;
    logic                  retire_reg;
    logic                  wb_exit;

    // An instruction retires on the edge that leaves WB.
    assign wb_exit = (state_reg == PH_WB) && !stall_writeback;

    always_comb begin
        state_next        = state_reg;
        step_pending_next = step_pending_reg;
        case (state_reg)
            PH_RST: begin
                state_next = PH_FETCH;
            end
            PH_FETCH: begin
                if (!stall_fetch) state_next = PH_DECODE;
            end
            PH_DECODE: begin
                if (!stall_decode) state_next = PH_EXECUTE;
            end
            PH_EXECUTE: begin
                if (!stall_execute) state_next = PH_MEMACC;
            end
            PH_MEMACC: begin
                if (!stall_memoryaccess) state_next = PH_WB;
            end
            PH_WB: begin
                // halt_req is only looked at on the exit edge, so a WB stall
                // always completes the instruction before halting.
                if (!stall_writeback) begin
                    state_next        = (halt_req || step_pending_reg) ? PH_HALT : PH_FETCH;
                    step_pending_next = 1'b0;
                end
            end
            PH_HALT: begin
                // Step takes priority: it runs one instruction and the pending
                // flag forces a return to HALT even if halt_req has dropped.
                if (step_req) begin
                    state_next        = PH_FETCH;
                    step_pending_next = 1'b1;
                end else if (!halt_req) begin
                    state_next        = PH_FETCH;
                    step_pending_next = 1'b0;
                end
            end
            default: begin
                state_next        = PH_RST;
                step_pending_next = 1'b0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they line up with state_reg.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= PH_RST;
            step_pending_reg <= 1'b0;
            onehot_reg       <= '0;
            retire_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            step_pending_reg <= step_pending_next;
            onehot_reg       <= phase_onehot(state_next);
            retire_reg       <= wb_exit;
        end
    end

    assign phase_fetch        = onehot_reg[OH_FETCH];
    assign phase_decode       = onehot_reg[OH_DECODE];
    assign phase_execute      = onehot_reg[OH_EXECUTE];
    assign phase_memoryaccess = onehot_reg[OH_MEMACC];
    assign phase_writeback    = onehot_reg[OH_WB];
    assign halted             = onehot_reg[OH_HALT];
    assign retire             = retire_reg;

    // Counter 0 counts active cycles, counter 1 counts retirements.
    logic            cnt_clr;
    logic [1:0]      cnt_en;
    logic [CNTW-1:0] cnt_val [2];

    assign cnt_clr   = !rst_n;
    assign cnt_en[0] = counts_cycle(state_reg);
    assign cnt_en[1] = wb_exit;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        core_phase_sequencer_phase_counter #(
            .CNTW (CNTW)
        ) u_cnt (
            .clk (clk),
            .clr (cnt_clr),
            .en  (cnt_en[gi]),
            .cnt (cnt_val[gi])
        );
    end

    assign cycle_cnt   = cnt_val[0];
    assign instret_cnt = cnt_val[1];

endmodule
